// File: rtl/picomips_pkg.sv
// Shared types and defaults for the picoMIPS program-counter controller.
package picomips_pkg;

    localparam int PC_WIDTH_DEFAULT = 7;

    typedef enum logic [1:0] {
        RUN,
        WAIT_PRESS,
        WAIT_RELEASE,
        HALTED
    } pc_state_t;

endpackage

// File: rtl/pc_controller_handshake_sync.sv
// Multi-stage synchroniser bringing the asynchronous handshake switch into the clock domain.
module handshake_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] stages_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stages_q <= '0;
        end else begin
            stages_q[0] <= async_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stages_q[i] <= stages_q[i-1];
            end
        end
    end

    assign sync_o = stages_q[SYNC_STAGES-1];

endmodule

// File: rtl/pc_controller.sv
// Program-counter controller: sequences RUN / handshake wait / HALTED and owns the PC register.
module pc_controller
    import picomips_pkg::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Halt,
    input  logic                WaitReq,
    input  logic                Jump,
    input  logic [PC_WIDTH-1:0] Target,
    input  logic                Branch,
    input  logic                Zero,
    input  logic [PC_WIDTH-1:0] Offset,
    input  logic                Handshake,
    output logic [PC_WIDTH-1:0] ProgramCounter,
    output logic                Stalled
);

    logic                HsSync;
    pc_state_t           state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                stalled_q, stalled_d;
    logic [PC_WIDTH-1:0] pcPlusOne, pcPlusOffset;

    handshake_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (Clock),
        .rst_i  (Reset),
        .async_i(Handshake),
        .sync_o (HsSync)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= RUN;
            pc_q      <= '0;
            stalled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            stalled_q <= stalled_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (Halt) begin
                    state_d = HALTED;
                end else if (WaitReq) begin
                    state_d = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                if (HsSync) begin
                    state_d = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (!HsSync) begin
                    state_d = RUN;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // Both adders wrap modulo 2^PC_WIDTH; a single mux selects the next PC.
    assign pcPlusOne    = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    assign pcPlusOffset = pc_q + Offset;

    always_comb begin
        pc_d      = pc_q;
        stalled_d = (state_d != RUN);
        case (state_q)
            RUN: begin
                if (!Halt && !WaitReq) begin
                    if (Jump) begin
                        pc_d = Target;
                    end else if (Branch && Zero) begin
                        pc_d = pcPlusOffset;
                    end else begin
                        pc_d = pcPlusOne;
                    end
                end
            end
            WAIT_RELEASE: begin
                if (!HsSync) begin
                    pc_d = pcPlusOne;
                end
            end
            default: pc_d = pc_q;
        endcase
    end

    assign ProgramCounter = pc_q;
    assign Stalled        = stalled_q;

endmodule

// File: tb/tb_pc_controller.sv
// Scoreboard-driven bench for pc_controller: expected PC/Stalled pairs are queued as stimulus is driven.
module tb_pc_controller;

    localparam int W = 7;

    logic         Clock, Reset, Halt, WaitReq, Jump, Branch, Zero, Handshake;
    logic [W-1:0] Target, Offset;
    logic [W-1:0] ProgramCounter;
    logic         Stalled;

    int compared   = 0;
    int mismatched = 0;

    logic [W-1:0] expPcQ[$];
    logic         expStQ[$];

    pc_controller #(
        .PC_WIDTH   (W),
        .SYNC_STAGES(2)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .Halt          (Halt),
        .WaitReq       (WaitReq),
        .Jump          (Jump),
        .Target        (Target),
        .Branch        (Branch),
        .Zero          (Zero),
        .Offset        (Offset),
        .Handshake     (Handshake),
        .ProgramCounter(ProgramCounter),
        .Stalled       (Stalled)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic clearInputs();
        Halt = 0; WaitReq = 0; Jump = 0; Branch = 0; Zero = 0;
        Target = '0; Offset = '0; Handshake = 0;
    endtask

    task automatic gotoPc(input logic [W-1:0] t);
        Jump = 1; Target = t;
        cycle();
        Jump = 0; Target = '0;
    endtask

    task automatic test_reset();
        logic [W-1:0] ep; logic es;
        clearInputs();
        Reset = 1;
        #2;
        expPcQ.push_back(7'd0); expStQ.push_back(1'b0);
        ep = expPcQ.pop_front(); es = expStQ.pop_front(); compared++;
        if (ProgramCounter !== ep || Stalled !== es) begin
            mismatched++;
            $display("[TB] FAIL reset_async: pc=%0d stalled=%b expected pc=%0d stalled=%b", ProgramCounter, Stalled, ep, es);
        end
        repeat (2) cycle();
        expPcQ.push_back(7'd0); expStQ.push_back(1'b0);
        ep = expPcQ.pop_front(); es = expStQ.pop_front(); compared++;
        if (ProgramCounter !== ep || Stalled !== es) begin
            mismatched++;
            $display("[TB] FAIL reset_held: pc=%0d stalled=%b expected pc=%0d stalled=%b", ProgramCounter, Stalled, ep, es);
        end
        Reset = 0;
    endtask

    task automatic test_count();
        logic [W-1:0] ep; logic es;
        for (int k = 1; k <= 130; k++) begin
            expPcQ.push_back(W'(k % 128)); expStQ.push_back(1'b0);
            cycle();
            ep = expPcQ.pop_front(); es = expStQ.pop_front(); compared++;
            if (ProgramCounter !== ep || Stalled !== es) begin
                mismatched++;
                $display("[TB] FAIL count[%0d]: pc=%0d stalled=%b expected pc=%0d stalled=%b", k, ProgramCounter, Stalled, ep, es);
            end
        end
    endtask

    task automatic test_branch();
        logic [W-1:0] ep; logic es;
        logic [W-1:0] startPc [4] = '{7'd10, 7'd10, 7'd2,   7'd120};
        logic         zeroIn  [4] = '{1'b1,  1'b0,  1'b1,   1'b1};
        logic [W-1:0] offIn   [4] = '{7'h7C, 7'h7C, 7'h7C,  7'd10};
        logic [W-1:0] expPc   [4] = '{7'd6,  7'd11, 7'd126, 7'd2};
        for (int i = 0; i < 4; i++) begin
            gotoPc(startPc[i]);
            Branch = 1; Zero = zeroIn[i]; Offset = offIn[i];
            expPcQ.push_back(expPc[i]); expStQ.push_back(1'b0);
            cycle();
            clearInputs();
            ep = expPcQ.pop_front(); es = expStQ.pop_front(); compared++;
            if (ProgramCounter !== ep || Stalled !== es) begin
                mismatched++;
                $display("[TB] FAIL branch[%0d]: pc=%0d stalled=%b expected pc=%0d stalled=%b", i, ProgramCounter, Stalled, ep, es);
            end
        end
    endtask

    task automatic test_priority();
        logic [W-1:0] ep; logic es;
        gotoPc(7'd5);
        Jump = 1; Branch = 1; Zero = 1; Target = 7'd40; Offset = 7'd3;
        expPcQ.push_back(7'd40); expStQ.push_back(1'b0);
        cycle();
        clearInputs();
        ep = expPcQ.pop_front(); es = expStQ.pop_front(); compared++;
        if (ProgramCounter !== ep || Stalled !== es) begin
            mismatched++;
            $display("[TB] FAIL jump_over_branch: pc=%0d stalled=%b expected pc=%0d stalled=%b", ProgramCounter, Stalled, ep, es);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ep; logic es;
        logic         jIn [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1,   1'b0, 1'b0};
        logic         bIn [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0,   1'b0, 1'b1};
        logic         zIn [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,   1'b0, 1'b1};
        logic [W-1:0] tIn [7] = '{7'd3, 7'd0, 7'd0, 7'd0, 7'd127, 7'd0, 7'd0};
        logic [W-1:0] oIn [7] = '{7'd0, 7'd5, 7'd5, 7'd0, 7'd0,   7'd0, 7'h7F};
        logic [W-1:0] eIn [7] = '{7'd3, 7'd8, 7'd9, 7'd10, 7'd127, 7'd0, 7'd127};
        for (int i = 0; i < 7; i++) begin
            Jump = jIn[i]; Branch = bIn[i]; Zero = zIn[i]; Target = tIn[i]; Offset = oIn[i];
            expPcQ.push_back(eIn[i]); expStQ.push_back(1'b0);
            cycle();
            ep = expPcQ.pop_front(); es = expStQ.pop_front(); compared++;
            if (ProgramCounter !== ep || Stalled !== es) begin
                mismatched++;
                $display("[TB] FAIL b2b[%0d]: pc=%0d stalled=%b expected pc=%0d stalled=%b", i, ProgramCounter, Stalled, ep, es);
            end
        end
        clearInputs();
    endtask

    // Handshake high for edges 2..6; two sync stages delay the release so RUN resumes on edge 9.
    task automatic test_handshake();
        logic [W-1:0] ep; logic es;
        gotoPc(7'd20);
        for (int k = 1; k <= 10; k++) begin
            WaitReq   = (k == 1);
            Jump      = (k <= 9);
            Target    = 7'd99;
            Handshake = (k >= 2 && k <= 6);
            if (k < 9) begin
                expPcQ.push_back(7'd20); expStQ.push_back(1'b1);
            end else begin
                expPcQ.push_back(k == 9 ? 7'd21 : 7'd22); expStQ.push_back(1'b0);
            end
            if (k == 10) begin
                Jump = 0;
            end
            cycle();
            ep = expPcQ.pop_front(); es = expStQ.pop_front(); compared++;
            if (ProgramCounter !== ep || Stalled !== es) begin
                mismatched++;
                $display("[TB] FAIL handshake[%0d]: pc=%0d stalled=%b expected pc=%0d stalled=%b", k, ProgramCounter, Stalled, ep, es);
            end
        end
        clearInputs();
    endtask

    task automatic test_halt();
        logic [W-1:0] ep; logic es;
        gotoPc(7'd33);
        Halt = 1; WaitReq = 1; Jump = 1; Target = 7'd5;
        for (int i = 0; i <= 50; i++) begin
            if (i > 0) begin
                Halt      = 1'($urandom_range(1));
                WaitReq   = 1'($urandom_range(1));
                Jump      = 1'($urandom_range(1));
                Branch    = 1'($urandom_range(1));
                Zero      = 1'($urandom_range(1));
                Target    = W'($urandom_range(127));
                Offset    = W'($urandom_range(127));
                Handshake = ((i / 4) % 2) == 1;
            end
            expPcQ.push_back(7'd33); expStQ.push_back(1'b1);
            cycle();
            ep = expPcQ.pop_front(); es = expStQ.pop_front(); compared++;
            if (ProgramCounter !== ep || Stalled !== es) begin
                mismatched++;
                $display("[TB] FAIL halted[%0d]: pc=%0d stalled=%b expected pc=%0d stalled=%b", i, ProgramCounter, Stalled, ep, es);
            end
        end
        clearInputs();
        #2 Reset = 1;
        #1;
        expPcQ.push_back(7'd0); expStQ.push_back(1'b0);
        ep = expPcQ.pop_front(); es = expStQ.pop_front(); compared++;
        if (ProgramCounter !== ep || Stalled !== es) begin
            mismatched++;
            $display("[TB] FAIL halt_reset_async: pc=%0d stalled=%b expected pc=%0d stalled=%b", ProgramCounter, Stalled, ep, es);
        end
        cycle();
        Reset = 0;
        expPcQ.push_back(7'd1); expStQ.push_back(1'b0);
        cycle();
        ep = expPcQ.pop_front(); es = expStQ.pop_front(); compared++;
        if (ProgramCounter !== ep || Stalled !== es) begin
            mismatched++;
            $display("[TB] FAIL halt_after_reset: pc=%0d stalled=%b expected pc=%0d stalled=%b", ProgramCounter, Stalled, ep, es);
        end
    endtask

    task automatic test_reset_mid_handshake();
        logic [W-1:0] ep; logic es;
        gotoPc(7'd50);
        for (int k = 1; k <= 5; k++) begin
            WaitReq   = (k == 1);
            Handshake = (k >= 2);
            expPcQ.push_back(7'd50); expStQ.push_back(1'b1);
            cycle();
            ep = expPcQ.pop_front(); es = expStQ.pop_front(); compared++;
            if (ProgramCounter !== ep || Stalled !== es) begin
                mismatched++;
                $display("[TB] FAIL mid_hs_wait[%0d]: pc=%0d stalled=%b expected pc=%0d stalled=%b", k, ProgramCounter, Stalled, ep, es);
            end
        end
        #2 Reset = 1;
        #1;
        expPcQ.push_back(7'd0); expStQ.push_back(1'b0);
        ep = expPcQ.pop_front(); es = expStQ.pop_front(); compared++;
        if (ProgramCounter !== ep || Stalled !== es) begin
            mismatched++;
            $display("[TB] FAIL mid_hs_reset_async: pc=%0d stalled=%b expected pc=%0d stalled=%b", ProgramCounter, Stalled, ep, es);
        end
        cycle();
        Reset = 0;
        for (int k = 1; k <= 3; k++) begin
            expPcQ.push_back(W'(k)); expStQ.push_back(1'b0);
            cycle();
            ep = expPcQ.pop_front(); es = expStQ.pop_front(); compared++;
            if (ProgramCounter !== ep || Stalled !== es) begin
                mismatched++;
                $display("[TB] FAIL mid_hs_resume[%0d]: pc=%0d stalled=%b expected pc=%0d stalled=%b", k, ProgramCounter, Stalled, ep, es);
            end
        end
        clearInputs();
    endtask

    initial begin
        test_reset();
        test_count();
        test_branch();
        test_priority();
        test_back_to_back();
        test_handshake();
        test_halt();
        test_reset_mid_handshake();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
